axi4_ar_fifo: RTL and testbench
===============================

Name: axi4_ar_fifo

Overview:
- Parametrised AXI4 read-address (AR) channel FIFO for the RAB slave and master ports; successor of the fixed single-stage AR buffer.
- Adds configurable address, ID and user widths, configurable depth, an optional fall-through mode, occupancy/almost-full status, and a synchronous flush used when RAB reconfiguration drains the port.

Parameters:
- AXI_ADDR_WIDTH, 32, araddr width (>=12).
- AXI_ID_WIDTH, 4, arid width (>=1).
- AXI_USER_WIDTH, 4, aruser width (>=1).
- DEPTH, 4, entries; power of two, >=2.
- FALL_THROUGH, 0, 0 = registered output; 1 = combinational bypass when empty.
- ALMOST_FULL_TH, DEPTH-1, level at or above which almost_full asserts (1..DEPTH).

Ports:
- axi4_aclk in 1: clock, all logic on rising edge.
- axi4_arst in 1: reset, synchronous, active-high.
- flush_i in 1: synchronous drop of all stored entries.
- s_axi4_arid/araddr/arlen/arsize/arburst/arlock/arprot/arcache/aruser in ID/ADDR/8/3/2/1/3/4/USER: slave AR payload.
- s_axi4_arvalid in 1; s_axi4_arready out 1.
- m_axi4_arid/araddr/arlen/arsize/arburst/arlock/arprot/arcache/aruser out, same widths: master AR payload.
- m_axi4_arvalid out 1; m_axi4_arready in 1.
- level_o out $clog2(DEPTH+1): stored entry count.
- almost_full_o out 1: level_o >= ALMOST_FULL_TH.

Behaviour:
- Storage: DEPTH x (ADDR+ID+USER+21)-bit circular array; wr_ptr, rd_ptr $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0; count register 0..DEPTH.
- Reset (axi4_arst=1 at an edge): ptrs=0, count=0. While axi4_arst is high: s_axi4_arready=0, m_axi4_arvalid=0, level_o=0, almost_full_o=0. s_axi4_arready=1 from the first cycle after release. Array contents are not reset; m payload is don't-care while arvalid=0.
- Reset mid-transfer: stored entries are discarded; no handshake completes on a cycle with axi4_arst=1.
- push = s_arvalid & s_arready; pop = m_arvalid & m_arready (stored entries only).
- s_axi4_arready = !full & !flush_i & !axi4_arst; depends only on registers and these inputs, never on m_axi4_arready.
- FALL_THROUGH=0: m_axi4_arvalid = (count!=0); payload = array[rd_ptr]. Latency: entry pushed at edge N is presented from cycle N+1.
- FALL_THROUGH=1, count==0: m_axi4_arvalid = s_axi4_arvalid & !flush_i & !axi4_arst; payload = s payload; if m_arready=1 that cycle, the beat passes through with zero latency, is not written, and count stays 0. If m_arready=0, the beat is written (push) and presented from storage next cycle. With count!=0, identical to FALL_THROUGH=0.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged, both ptrs advance.
- Full (count==DEPTH): s_arready=0; a pop frees an entry, with arready returning the following cycle.
- Empty: m_arvalid=0 (except fall-through bypass).
- AXI stability: once m_arvalid=1, payload and valid hold until pop; an upstream beat held with arvalid=1/arready=0 is accepted as-is when space appears.
- flush_i=1 at an edge: ptrs=0, count=0; during that cycle s_arready=0 and m_arvalid=0, so no push or pop occurs. Reset has priority over flush.
- level_o = count (registered); almost_full_o registered from next count, so both are valid in the same cycle as the count they describe.

Test Plan:
- Reset: hold axi4_arst 3 cycles with s_arvalid=1 -> s_arready=0, m_arvalid=0, level_o=0 throughout; s_arready=1 first cycle after release.
- Fill/drain, DEPTH=4, FALL_THROUGH=0, m_arready=0: push araddr 0x1000,0x2000,0x3000,0x4000 on consecutive cycles -> level_o 1,2,3,4; almost_full_o high at level 3; s_arready=0 at level 4. Then m_arready=1 -> addresses drain in order 0x1000..0x4000 with matching arid/aruser, one per cycle.
- Streaming: continuous s_arvalid and m_arready for 20 beats, random payload, arid=i -> every cycle completes a push and pop after the first-cycle latency; level_o stays 1; output order equals input order.
- Fall-through, FALL_THROUGH=1, empty, m_arready=1: push araddr 0xDEAD0000 -> same-cycle m_arvalid=1 with that address; level_o stays 0. Repeat with m_arready=0 -> level_o=1 next cycle and the beat is held stable.
- Flush: level_o=3, assert flush_i one cycle while s_arvalid=1 -> no accept that cycle, level_o=0 and m_arvalid=0 next cycle; the next push emerges first.
- Wrap/backpressure: random m_arready (50%), 1000 beats, DEPTH=8, AXI_ADDR_WIDTH=64, ID=6, USER=8 -> scoreboard exact in-order match, no loss or duplication, payload stable while m_arvalid & !m_arready.

Source files
------------

// File: rtl/axi4_ar_fifo_if.sv
// AXI4 read-address channel bundle: payload, valid and ready.
// The master drives payload and valid; the slave returns ready.
interface axi4_ar_fifo_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int USER_WIDTH = 4
);
   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arlock;
   logic [2:0]            arprot;
   logic [3:0]            arcache;
   logic [USER_WIDTH-1:0] aruser;
   logic                  arvalid;
   logic                  arready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arprot, arcache, aruser, arvalid,
      input  arready
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arprot, arcache, aruser, arvalid,
      output arready
   );
endinterface

// File: rtl/axi4_ar_fifo.sv
// Parametrised AXI4 AR channel FIFO with optional fall-through bypass,
// occupancy/almost-full status and synchronous flush.
module axi4_ar_fifo #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_USER_WIDTH = 4,
   parameter int DEPTH          = 4,
   parameter int FALL_THROUGH   = 0,
   parameter int ALMOST_FULL_TH = DEPTH - 1
) (
   input  logic                         axi4_aclk,
   input  logic                         axi4_arst,
   input  logic                         flush_i,
   axi4_ar_fifo_if.slave                s_axi4,
   axi4_ar_fifo_if.master               m_axi4,
   output logic [$clog2(DEPTH+1)-1:0]   level_o,
   output logic                         almost_full_o
);
   localparam int  PW = $clog2(DEPTH);
   localparam int  CW = $clog2(DEPTH + 1);
   localparam int  W  = AXI_ADDR_WIDTH + AXI_ID_WIDTH + AXI_USER_WIDTH + 21;
   localparam bit  FT = (FALL_THROUGH != 0);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic          af_q;
   logic          full;
   logic          empty;
   logic          bypass;
   logic          push;
   logic          pop;
   logic          wr_en;
   logic [W-1:0]  s_entry;
   logic [W-1:0]  rd_entry;

   assign s_entry = {s_axi4.arid, s_axi4.araddr, s_axi4.arlen, s_axi4.arsize, s_axi4.arburst,
                     s_axi4.arlock, s_axi4.arprot, s_axi4.arcache, s_axi4.aruser};
   assign rd_entry = mem[rd_ptr];

   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign bypass = FT && empty;

   // Ready never looks at the downstream side, so no combinational ready path crosses the FIFO.
   assign s_axi4.arready = !full && !flush_i && !axi4_arst;
   assign m_axi4.arvalid = !flush_i && !axi4_arst && (empty ? (bypass && s_axi4.arvalid) : 1'b1);

   assign {m_axi4.arid, m_axi4.araddr, m_axi4.arlen, m_axi4.arsize, m_axi4.arburst,
           m_axi4.arlock, m_axi4.arprot, m_axi4.arcache, m_axi4.aruser} = bypass ? s_entry : rd_entry;

   assign push = s_axi4.arvalid && s_axi4.arready;
   assign pop  = m_axi4.arvalid && m_axi4.arready && !empty;
   // A bypassed beat taken downstream in the same cycle never occupies storage.
   assign wr_en     = push && !(bypass && m_axi4.arready);
   assign count_nxt = count + CW'(wr_en) - CW'(pop);

   always_ff @(posedge axi4_aclk) begin
      if (axi4_arst || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         af_q   <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (pop)   rd_ptr <= rd_ptr + PW'(1);
         count <= count_nxt;
         af_q  <= (count_nxt >= CW'(ALMOST_FULL_TH));
      end
   end

   always_ff @(posedge axi4_aclk) begin
      if (wr_en) mem[wr_ptr] <= s_entry;
   end

   assign level_o       = axi4_arst ? '0 : count;
   assign almost_full_o = af_q && !axi4_arst;
endmodule

// File: tb/tb_axi4_ar_fifo.sv
// Bench for axi4_ar_fifo: a registered DEPTH=4 instance and a wide
// fall-through DEPTH=8 instance, each with its own scoreboard monitor.
module tb_axi4_ar_fifo;
   logic clk = 1'b0;
   logic rst;
   logic flush0, flush1;
   logic [2:0] lvl0;
   logic [3:0] lvl1;
   logic af0, af1;
   int errors = 0;
   int checks = 0;
   int pops0 = 0, pops1 = 0;

   always #5 clk = ~clk;

   axi4_ar_fifo_if #(.ADDR_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(4)) a_s ();
   axi4_ar_fifo_if #(.ADDR_WIDTH(32), .ID_WIDTH(4), .USER_WIDTH(4)) a_m ();
   axi4_ar_fifo_if #(.ADDR_WIDTH(64), .ID_WIDTH(6), .USER_WIDTH(8)) b_s ();
   axi4_ar_fifo_if #(.ADDR_WIDTH(64), .ID_WIDTH(6), .USER_WIDTH(8)) b_m ();

   axi4_ar_fifo #(.AXI_ADDR_WIDTH(32), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(4),
                  .DEPTH(4), .FALL_THROUGH(0)) dut0 (
      .axi4_aclk(clk), .axi4_arst(rst), .flush_i(flush0),
      .s_axi4(a_s.slave), .m_axi4(a_m.master),
      .level_o(lvl0), .almost_full_o(af0));

   axi4_ar_fifo #(.AXI_ADDR_WIDTH(64), .AXI_ID_WIDTH(6), .AXI_USER_WIDTH(8),
                  .DEPTH(8), .FALL_THROUGH(1)) dut1 (
      .axi4_aclk(clk), .axi4_arst(rst), .flush_i(flush1),
      .s_axi4(b_s.slave), .m_axi4(b_m.master),
      .level_o(lvl1), .almost_full_o(af1));

   logic [127:0] pk_s0, pk_m0, pk_s1, pk_m1;
   assign pk_s0 = 128'({a_s.arid, a_s.araddr, a_s.arlen, a_s.arsize, a_s.arburst,
                        a_s.arlock, a_s.arprot, a_s.arcache, a_s.aruser});
   assign pk_m0 = 128'({a_m.arid, a_m.araddr, a_m.arlen, a_m.arsize, a_m.arburst,
                        a_m.arlock, a_m.arprot, a_m.arcache, a_m.aruser});
   assign pk_s1 = 128'({b_s.arid, b_s.araddr, b_s.arlen, b_s.arsize, b_s.arburst,
                        b_s.arlock, b_s.arprot, b_s.arcache, b_s.aruser});
   assign pk_m1 = 128'({b_m.arid, b_m.araddr, b_m.arlen, b_m.arsize, b_m.arburst,
                        b_m.arlock, b_m.arprot, b_m.arcache, b_m.aruser});

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Scoreboard monitors: accepted input beats are queued, output beats must match in order.
   logic [127:0] q0[$], q1[$];
   logic [127:0] prev0, prev1;
   bit hold0 = 0, hold1 = 0;

   always @(negedge clk) begin
      if (rst || flush0) begin
         q0.delete();
         hold0 = 0;
      end else begin
         if (hold0) begin
            chk("dut0 hold valid", 128'(a_m.arvalid), 128'(1));
            chk("dut0 hold payload", pk_m0, prev0);
         end
         if (a_s.arvalid && a_s.arready) q0.push_back(pk_s0);
         if (a_m.arvalid && a_m.arready) begin
            pops0++;
            if (q0.size() == 0) begin
               checks++; errors++;
               $display("FAIL dut0 beat: got %0h expected nothing (scoreboard empty)", pk_m0);
            end else chk("dut0 beat", pk_m0, q0.pop_front());
         end
         hold0 = a_m.arvalid && !a_m.arready;
         prev0 = pk_m0;
      end
   end

   always @(negedge clk) begin
      if (rst || flush1) begin
         q1.delete();
         hold1 = 0;
      end else begin
         if (hold1) begin
            chk("dut1 hold valid", 128'(b_m.arvalid), 128'(1));
            chk("dut1 hold payload", pk_m1, prev1);
         end
         if (b_s.arvalid && b_s.arready) q1.push_back(pk_s1);
         if (b_m.arvalid && b_m.arready) begin
            pops1++;
            if (q1.size() == 0) begin
               checks++; errors++;
               $display("FAIL dut1 beat: got %0h expected nothing (scoreboard empty)", pk_m1);
            end else chk("dut1 beat", pk_m1, q1.pop_front());
         end
         hold1 = b_m.arvalid && !b_m.arready;
         prev1 = pk_m1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] user);
      a_s.araddr = addr; a_s.arid = id; a_s.aruser = user;
      a_s.arlen = {4'h0, id}; a_s.arsize = 3'd2; a_s.arburst = 2'b01;
      a_s.arlock = id[0]; a_s.arprot = id[2:0]; a_s.arcache = ~user;
   endtask

   task automatic drive1(input logic [63:0] addr);
      b_s.araddr = addr; b_s.arid = 6'h2A; b_s.aruser = 8'h5C;
      b_s.arlen = 8'h0F; b_s.arsize = 3'd3; b_s.arburst = 2'b10;
      b_s.arlock = 1'b0; b_s.arprot = 3'd5; b_s.arcache = 4'h3;
   endtask

   task automatic rand1();
      b_s.araddr = {$urandom(), $urandom()}; b_s.arid = 6'($urandom()); b_s.aruser = 8'($urandom());
      b_s.arlen = 8'($urandom()); b_s.arsize = 3'($urandom()); b_s.arburst = 2'($urandom());
      b_s.arlock = 1'($urandom()); b_s.arprot = 3'($urandom()); b_s.arcache = 4'($urandom());
   endtask

   task automatic drain0(input int base, input int n);
      for (int k = 0; k < 12 && (lvl0 != 0 || a_m.arvalid); k++) tick();
      @(negedge clk);
      chk("dut0 drained level", 128'(lvl0), 128'(0));
      chk("dut0 drained count", 128'(pops0 - base), 128'(n));
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, sent, cyc;
      bit acc;
      rst = 1; flush0 = 0; flush1 = 0;
      drive0(32'h0, 4'h0, 4'h0); drive1(64'h0);
      a_s.arvalid = 1; b_s.arvalid = 1;
      a_m.arready = 0; b_m.arready = 0;

      // Reset held three cycles with upstream valid asserted.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst s_arready", 128'(a_s.arready), 128'(0));
         chk("rst m_arvalid", 128'(a_m.arvalid), 128'(0));
         chk("rst level", 128'(lvl0), 128'(0));
         chk("rst ft m_arvalid", 128'(b_m.arvalid), 128'(0));
         tick();
      end
      rst = 0; a_s.arvalid = 0; b_s.arvalid = 0;
      @(negedge clk);
      chk("post-rst s_arready", 128'(a_s.arready), 128'(1));
      chk("post-rst level", 128'(lvl0), 128'(0));
      tick();

      // Fill with downstream stalled.
      for (int i = 0; i < 4; i++) begin
         drive0(32'h1000 * (i + 1), 4'(i + 1), 4'(4'hA ^ i));
         a_s.arvalid = 1;
         @(negedge clk);
         chk("fill level", 128'(lvl0), 128'(i));
         chk("fill almost_full", 128'(af0), 128'(i >= 3));
         chk("fill s_arready", 128'(a_s.arready), 128'(1));
         if (i > 0) chk("fill head addr", 128'(a_m.araddr), 128'(32'h1000));
         tick();
      end
      // Fifth beat waits while full; one pop frees space the following cycle.
      drive0(32'h5000, 4'h5, 4'hF);
      a_m.arready = 1;
      @(negedge clk);
      chk("full level", 128'(lvl0), 128'(4));
      chk("full almost_full", 128'(af0), 128'(1));
      chk("full s_arready", 128'(a_s.arready), 128'(0));
      tick();
      @(negedge clk);
      chk("freed level", 128'(lvl0), 128'(3));
      chk("freed s_arready", 128'(a_s.arready), 128'(1));
      tick();
      a_s.arvalid = 0;
      drain0(0, 5);

      // Streaming: one push and one pop per cycle.
      base = pops0;
      a_m.arready = 1;
      for (int i = 0; i < 20; i++) begin
         drive0($urandom(), 4'(i), 4'($urandom()));
         a_s.arvalid = 1;
         @(negedge clk);
         chk("stream s_arready", 128'(a_s.arready), 128'(1));
         if (i > 0) begin
            chk("stream level", 128'(lvl0), 128'(1));
            chk("stream m_arvalid", 128'(a_m.arvalid), 128'(1));
         end
         tick();
      end
      a_s.arvalid = 0;
      drain0(base, 20);

      // Flush with three stored entries and an upstream beat pending.
      a_m.arready = 0;
      for (int i = 0; i < 3; i++) begin
         drive0(32'h100 + 32'(i), 4'(i), 4'h1);
         a_s.arvalid = 1;
         tick();
      end
      drive0(32'h7000, 4'h7, 4'h7);
      flush0 = 1;
      @(negedge clk);
      chk("flush level before", 128'(lvl0), 128'(3));
      chk("flush s_arready", 128'(a_s.arready), 128'(0));
      chk("flush m_arvalid", 128'(a_m.arvalid), 128'(0));
      tick();
      flush0 = 0;
      drive0(32'hF000, 4'hC, 4'h3);
      @(negedge clk);
      chk("flushed level", 128'(lvl0), 128'(0));
      chk("flushed m_arvalid", 128'(a_m.arvalid), 128'(0));
      tick();
      a_s.arvalid = 0; a_m.arready = 1;
      base = pops0;
      @(negedge clk);
      chk("after flush head", 128'(a_m.araddr), 128'(32'hF000));
      tick();
      drain0(base, 1);

      // Reset mid-transfer discards stored entries.
      a_m.arready = 0;
      for (int i = 0; i < 2; i++) begin
         drive0(32'h9000 + 32'(i), 4'(i), 4'h2);
         a_s.arvalid = 1;
         tick();
      end
      a_s.arvalid = 0; rst = 1;
      @(negedge clk);
      chk("mid-rst level", 128'(lvl0), 128'(0));
      chk("mid-rst m_arvalid", 128'(a_m.arvalid), 128'(0));
      tick();
      rst = 0;
      @(negedge clk);
      chk("after mid-rst level", 128'(lvl0), 128'(0));
      chk("after mid-rst m_arvalid", 128'(a_m.arvalid), 128'(0));
      chk("after mid-rst almost_full", 128'(af0), 128'(0));
      tick();

      // Fall-through: same-cycle bypass, then stalled bypass that is stored.
      base = pops1;
      b_m.arready = 1;
      drive1(64'hDEAD0000); b_s.arvalid = 1;
      @(negedge clk);
      chk("ft bypass valid", 128'(b_m.arvalid), 128'(1));
      chk("ft bypass addr", 128'(b_m.araddr), 128'(64'hDEAD0000));
      chk("ft bypass level", 128'(lvl1), 128'(0));
      tick();
      b_s.arvalid = 0;
      @(negedge clk);
      chk("ft after bypass level", 128'(lvl1), 128'(0));
      chk("ft after bypass valid", 128'(b_m.arvalid), 128'(0));
      tick();
      b_m.arready = 0;
      drive1(64'hDEAD0004); b_s.arvalid = 1;
      @(negedge clk);
      chk("ft stall valid", 128'(b_m.arvalid), 128'(1));
      tick();
      b_s.arvalid = 0;
      drive1(64'h0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("ft stored level", 128'(lvl1), 128'(1));
         chk("ft stored addr", 128'(b_m.araddr), 128'(64'hDEAD0004));
         tick();
      end
      b_m.arready = 1;
      tick();
      @(negedge clk);
      chk("ft popped count", 128'(pops1 - base), 128'(2));
      tick();

      // Random backpressure on the wide fall-through instance.
      base = pops1; sent = 0; cyc = 0; acc = 1'b1;
      while (sent < 1000 && cyc < 20000) begin
         if (acc || !b_s.arvalid) begin
            rand1();
            b_s.arvalid = ($urandom_range(0, 3) != 0);
         end
         b_m.arready = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         acc = b_s.arvalid && b_s.arready;
         if (acc) sent++;
         tick();
         cyc++;
      end
      b_s.arvalid = 0; b_m.arready = 1;
      for (int k = 0; k < 20 && (lvl1 != 0 || b_m.arvalid); k++) tick();
      @(negedge clk);
      chk("rand sent", 128'(sent), 128'(1000));
      chk("rand popped", 128'(pops1 - base), 128'(1000));
      chk("rand level", 128'(lvl1), 128'(0));
      chk("rand almost_full", 128'(af1), 128'(0));
      chk("sb0 empty", 128'(q0.size()), 128'(0));
      chk("sb1 empty", 128'(q1.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
